// File: rtl/vmac_pkg.sv
// Shared constants and state encoding for the vector MAC operand path.
// Used by vec_mac_feeder, vector_mac_top and their benches.
// No logic; parameters here must agree with the MAC core build.
package vmac_pkg;

  // Beats per MAC window; each beat carries VMAC_LANES elements.
  localparam int VMAC_BEATS  = 250;
  localparam int VMAC_LANES  = 4;
  localparam int VMAC_LANE_W = 8;
  localparam int VMAC_ACC_W  = 32;
  localparam int VMAC_WORD_W = VMAC_LANES * VMAC_LANE_W;

  // Feeder control states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CREDIT = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } vmac_state_e;

endpackage

// File: rtl/vmf_result_fifo.sv
// Generic synchronous FIFO holding MAC results for downstream readout.
// Latency: a push is visible at head_dat/!empty the cycle after it is written.
// Backpressure: push is dropped only when full without a same-cycle pop; pop on empty is ignored.
module vmf_result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign count    = count_q;
  // Pop only real entries; at full a concurrent pop frees the slot for the push.
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  // Head reads as zero when empty so the output is clean out of reset.
  assign head_dat = empty ? '0 : mem_q[rd_ptr_q];

  // Storage array, written on accepted push only.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_dat;
    end
  end

  // Pointers and occupancy; power-of-2 depth lets pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/vec_mac_feeder.sv
// Reads packed 4xINT8 operands from two SRAMs, streams them to the MAC core, queues results.
// Latency: >=1 cycle accept-to-first-read; in_valid follows rd_en by 1 cycle (SRAM read latency).
// Backpressure: a window is issued only once a result slot is reserved; VMF_THROTTLE_EN halves beat rate.
module vec_mac_feeder
  import vmac_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int BEATS     = VMAC_BEATS,
  parameter int WIN_W     = 8,
  parameter int RES_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base_a,
  input  logic [ADDR_W-1:0] cmd_base_b,
  input  logic [WIN_W-1:0]  cmd_windows,
  output logic              a_rd_en,
  output logic              b_rd_en,
  output logic [ADDR_W-1:0] a_rd_addr,
  output logic [ADDR_W-1:0] b_rd_addr,
  input  logic [31:0]       a_rd_data,
  input  logic [31:0]       b_rd_data,
  output logic              in_valid,
  output logic [31:0]       in_a,
  output logic [31:0]       in_b,
  input  logic              out_valid,
  input  logic [31:0]       mac_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       res_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] S_IDLE   = 3'(ST_IDLE);
  localparam logic [2:0] S_CREDIT = 3'(ST_CREDIT);
  localparam logic [2:0] S_ISSUE  = 3'(ST_ISSUE);
  localparam logic [2:0] S_DRAIN  = 3'(ST_DRAIN);
  localparam logic [2:0] S_DONE   = 3'(ST_DONE);

  localparam int              BEAT_W    = $clog2(BEATS);
  localparam int              CNT_W     = $clog2(RES_DEPTH) + 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_a_q, addr_b_q;
  logic [WIN_W-1:0]  win_left_q;
  logic [BEAT_W-1:0] beat_q;
  logic [CNT_W-1:0]  outst_q;
  logic              err_q;
  logic              cmd_ready_q;
  logic              in_valid_q;
  logic [31:0]       hold_a_q, hold_b_q;

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W:0]    credit_used;
  logic              credit_ok;
  logic              cmd_acc;
  logic              reserve;
  logic              rd_fire;
  logic              last_beat;
  logic              res_push;
  logic              res_pop;
  logic              spurious;

`ifdef VMF_THROTTLE_EN
  // Alternates read and idle cycles inside a window.
  logic              phase_q;
`endif

  assign cmd_acc     = cmd_valid && cmd_ready_q;
  // Results already queued plus windows in flight must leave room for one more.
  assign credit_used = {1'b0, fifo_count} + {1'b0, outst_q};
  assign credit_ok   = !fifo_full && (credit_used < (CNT_W+1)'(RES_DEPTH));
  assign reserve     = (state_q == S_CREDIT) && credit_ok;
`ifdef VMF_THROTTLE_EN
  assign rd_fire     = (state_q == S_ISSUE) && !phase_q;
`else
  assign rd_fire     = (state_q == S_ISSUE);
`endif
  assign last_beat   = rd_fire && (beat_q == BEAT_LAST);
  assign res_push    = out_valid && (outst_q != '0);
  assign spurious    = out_valid && (outst_q == '0);
  assign res_pop     = res_valid && res_ready;

  assign a_rd_en   = rd_fire;
  assign b_rd_en   = rd_fire;
  assign a_rd_addr = addr_a_q;
  assign b_rd_addr = addr_b_q;

  // SRAM output is the beat register; the hold copy keeps in_a/in_b stable between beats.
  assign in_valid  = in_valid_q;
  assign in_a      = in_valid_q ? a_rd_data : hold_a_q;
  assign in_b      = in_valid_q ? b_rd_data : hold_b_q;

  assign cmd_ready = cmd_ready_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign res_valid = !fifo_empty;

  // Next-state selection for the command sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (cmd_acc) state_d = (cmd_windows == '0) ? S_DONE : S_CREDIT;
      S_CREDIT: if (credit_ok) state_d = S_ISSUE;
      S_ISSUE:  if (last_beat) state_d = (win_left_q == WIN_W'(1)) ? S_DRAIN : S_CREDIT;
      S_DRAIN:  if (outst_q == '0) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State register; cmd_ready is registered so it stays low while reset is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= (state_d == S_IDLE);
    end
  end

  // Address pointers, window and beat counters; addresses carry over between windows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      win_left_q <= '0;
      beat_q     <= '0;
    end else if (cmd_acc) begin
      addr_a_q   <= cmd_base_a;
      addr_b_q   <= cmd_base_b;
      win_left_q <= cmd_windows;
      beat_q     <= '0;
    end else if (rd_fire) begin
      addr_a_q <= addr_a_q + 1'b1;
      addr_b_q <= addr_b_q + 1'b1;
      if (last_beat) begin
        beat_q     <= '0;
        win_left_q <= win_left_q - 1'b1;
      end else begin
        beat_q <= beat_q + 1'b1;
      end
    end
  end

`ifdef VMF_THROTTLE_EN
  // Idle slot after every read except the last, so a window spans 2*BEATS-1 cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 1'b0;
    end else begin
      phase_q <= (state_q == S_ISSUE) && !phase_q && !last_beat;
    end
  end
`endif

  // Outstanding windows: reserve on issue, release on result; both together cancel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outst_q <= '0;
    end else begin
      case ({reserve, res_push})
        2'b10:   outst_q <= outst_q + 1'b1;
        2'b01:   outst_q <= outst_q - 1'b1;
        default: outst_q <= outst_q;
      endcase
    end
  end

  // Sticky error on an unexpected result; a new command clears it unless one arrives with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (spurious) begin
      err_q <= 1'b1;
    end else if (cmd_acc) begin
      err_q <= 1'b0;
    end
  end

  // Beat valid tracks the read strobe one cycle later; hold copies capture each beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_valid_q <= 1'b0;
      hold_a_q   <= '0;
      hold_b_q   <= '0;
    end else begin
      in_valid_q <= rd_fire;
      if (in_valid_q) begin
        hold_a_q <= a_rd_data;
        hold_b_q <= b_rd_data;
      end
    end
  end

  vmf_result_fifo #(
    .WIDTH (VMAC_ACC_W),
    .DEPTH (RES_DEPTH)
  ) u_res_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (res_push),
    .push_dat (mac_out),
    .pop      (res_pop),
    .head_dat (res_data),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_vec_mac_feeder.sv
// Directed bench for vec_mac_feeder with an SRAM model and a behavioural MAC core.
// Expected values are hand-computed constants for each stimulus pattern.
// Prints one FAIL line per mismatch and a final pass/total summary.
module tb_vec_mac_feeder;
  import vmac_pkg::*;

  localparam int ADDR_W = 12;
  localparam int WIN_W  = 8;
  localparam int BEATS  = 250;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_base_a = '0;
  logic [ADDR_W-1:0] cmd_base_b = '0;
  logic [WIN_W-1:0]  cmd_windows = '0;
  logic              a_rd_en, b_rd_en;
  logic [ADDR_W-1:0] a_rd_addr, b_rd_addr;
  logic [31:0]       a_rd_data = '0;
  logic [31:0]       b_rd_data = '0;
  logic              in_valid;
  logic [31:0]       in_a, in_b;
  logic              out_valid;
  logic [31:0]       mac_out;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [31:0]       res_data;
  logic              busy, done, err;

  always #5 clk = ~clk;

  vec_mac_feeder #(
    .ADDR_W(ADDR_W), .BEATS(BEATS), .WIN_W(WIN_W), .RES_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_base_a(cmd_base_a), .cmd_base_b(cmd_base_b), .cmd_windows(cmd_windows),
    .a_rd_en(a_rd_en), .b_rd_en(b_rd_en),
    .a_rd_addr(a_rd_addr), .b_rd_addr(b_rd_addr),
    .a_rd_data(a_rd_data), .b_rd_data(b_rd_data),
    .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .mac_out(mac_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .done(done), .err(err)
  );

  // SRAM contents pattern: 0 word=address, 1 all ones, 2 zeros, 3 A=1 and B=window+1.
  int mem_mode = 0;

  function automatic logic [31:0] sram_word(input logic [ADDR_W-1:0] addr, input bit is_b);
    case (mem_mode)
      0:       return {20'h0, addr};
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h0;
      default: return is_b ? ({20'h0, addr} / 32'd250 + 32'd1) : 32'd1;
    endcase
  endfunction

  // Single-port SRAMs with one-cycle read latency.
  always @(posedge clk) begin
    if (a_rd_en) a_rd_data <= sram_word(a_rd_addr, 1'b0);
    if (b_rd_en) b_rd_data <= sram_word(b_rd_addr, 1'b1);
  end

  function automatic logic [31:0] dot4(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] s;
    s = '0;
    for (int l = 0; l < 4; l++) s = s + 32'(a[8*l +: 8]) * 32'(b[8*l +: 8]);
    return s;
  endfunction

  // Behavioural MAC core: accumulates BEATS beats, then strobes the sum.
  logic [31:0] mac_acc;
  logic [31:0] mac_res;
  logic        mac_ov;
  int          mac_beats;
  logic        force_ov = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac_acc   <= '0;
      mac_res   <= '0;
      mac_ov    <= 1'b0;
      mac_beats <= 0;
    end else begin
      mac_ov <= 1'b0;
      if (in_valid) begin
        if (mac_beats == BEATS - 1) begin
          mac_ov    <= 1'b1;
          mac_res   <= mac_acc + dot4(in_a, in_b);
          mac_acc   <= '0;
          mac_beats <= 0;
        end else begin
          mac_acc   <= mac_acc + dot4(in_a, in_b);
          mac_beats <= mac_beats + 1;
        end
      end
    end
  end

  assign out_valid = mac_ov | force_ov;
  assign mac_out   = force_ov ? 32'hBAD0_BAD0 : mac_res;

  // Activity monitors.
  int                rd_beats = 0;
  int                iv_beats = 0;
  int                done_cnt = 0;
  logic [ADDR_W-1:0] a_addrs[$];
  logic [ADDR_W-1:0] b_addrs[$];
  logic [31:0]       pops[$];

  always @(posedge clk) begin
    if (a_rd_en) begin
      rd_beats <= rd_beats + 1;
      a_addrs.push_back(a_rd_addr);
      b_addrs.push_back(b_rd_addr);
    end
    if (in_valid) iv_beats <= iv_beats + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (res_valid && res_ready) pops.push_back(res_data);
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h (%0d) expected 0x%08h (%0d)", tag, got, got, exp, exp);
  endtask

  task automatic send_cmd(input logic [ADDR_W-1:0] ba, input logic [ADDR_W-1:0] bb,
                          input logic [WIN_W-1:0] w);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    cmd_base_a  = ba;
    cmd_base_b  = bb;
    cmd_windows = w;
    cmd_valid   = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string tag);
    int n;
    n = 0;
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(done), 32'd1);
  endtask

  int s_rd, s_iv, s_addr, s_pop, s_done, n;

  initial begin
    // Reset state.
    #12;
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check_eq("rst_busy",      32'(busy),      32'd0);
    check_eq("rst_outs",      32'({a_rd_en, b_rd_en, in_valid, res_valid, done, err}), 32'd0);
    check_eq("rst_in_a",      in_a,           32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    check_eq("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // Single window: sum of i*i for i=0..249.
    mem_mode = 0; res_ready = 1'b0;
    s_rd = rd_beats; s_iv = iv_beats; s_addr = a_addrs.size();
    send_cmd(12'h000, 12'h100, 8'd1);
    n = 0;
    while (!out_valid && n < 600) begin @(negedge clk); n++; end
    check_eq("single_out_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    check_eq("single_res_valid", 32'(res_valid), 32'd1);
    check_eq("single_res_data",  res_data,       32'd5177125);
    check_eq("single_rd_beats",  32'(rd_beats - s_rd), 32'd250);
    check_eq("single_iv_beats",  32'(iv_beats - s_iv), 32'd250);
    check_eq("single_a_first",   32'(a_addrs[s_addr]),       32'h000);
    check_eq("single_a_last",    32'(a_addrs[s_addr + 249]), 32'h0F9);
    check_eq("single_b_first",   32'(b_addrs[s_addr]),       32'h100);
    check_eq("single_b_last",    32'(b_addrs[s_addr + 249]), 32'h1F9);
    res_ready = 1'b1;
    wait_done(50, "single_done");
    check_eq("single_busy_at_done", 32'(busy), 32'd1);
    @(negedge clk);
    check_eq("single_busy_after", 32'(busy), 32'd0);
    check_eq("single_done_pulse", 32'(done), 32'd0);
    check_eq("single_popped", pops[pops.size() - 1], 32'd5177125);

    // Zero windows: straight to DONE, no reads, no results.
    s_rd = rd_beats; s_pop = pops.size();
    send_cmd(12'h010, 12'h020, 8'd0);
    @(negedge clk);
    check_eq("zero_done",  32'(done), 32'd1);
    @(negedge clk);
    check_eq("zero_idle",  32'({busy, done}), 32'd0);
    check_eq("zero_rd",    32'(rd_beats - s_rd), 32'd0);
    check_eq("zero_res",   32'(res_valid), 32'd0);
    check_eq("zero_pops",  32'(pops.size() - s_pop), 32'd0);

    // Backpressure: six windows, result path blocked, stalls after four.
    mem_mode = 3; res_ready = 1'b0;
    s_rd = rd_beats; s_pop = pops.size(); s_done = done_cnt;
    send_cmd(12'h000, 12'h000, 8'd6);
    repeat (1400) @(negedge clk);
    check_eq("bp_stall_rd",   32'(rd_beats - s_rd), 32'd1000);
    check_eq("bp_stall_busy", 32'(busy), 32'd1);
    check_eq("bp_stall_res",  32'(res_valid), 32'd1);
    check_eq("bp_stall_done", 32'(done_cnt - s_done), 32'd0);
    res_ready = 1'b1;
    wait_done(3000, "bp_done");
    @(negedge clk);
    check_eq("bp_rd_total", 32'(rd_beats - s_rd), 32'd1500);
    check_eq("bp_npops",    32'(pops.size() - s_pop), 32'd6);
    for (int k = 0; k < 6; k++) begin
      if (s_pop + k < pops.size())
        check_eq($sformatf("bp_res%0d", k), pops[s_pop + k], 32'(250 * (k + 1)));
      else
        check_eq($sformatf("bp_res%0d_missing", k), 32'd0, 32'(250 * (k + 1)));
    end

    // Address wrap at the top of a 12-bit space.
    mem_mode = 0;
    s_addr = a_addrs.size();
    send_cmd(12'hFF0, 12'h000, 8'd1);
    wait_done(600, "wrap_done");
    check_eq("wrap_count", 32'(a_addrs.size() - s_addr), 32'd250);
    check_eq("wrap_first", 32'(a_addrs[s_addr]),       32'hFF0);
    check_eq("wrap_top",   32'(a_addrs[s_addr + 15]),  32'hFFF);
    check_eq("wrap_zero",  32'(a_addrs[s_addr + 16]),  32'h000);
    check_eq("wrap_last",  32'(a_addrs[s_addr + 249]), 32'h0E9);

    // Boundary operands: all ones then all zeros.
    mem_mode = 1;
    send_cmd(12'h000, 12'h000, 8'd1);
    wait_done(600, "ones_done");
    @(negedge clk);
    check_eq("ones_result", pops[pops.size() - 1], 32'd65025000);
    mem_mode = 2;
    send_cmd(12'h000, 12'h000, 8'd1);
    wait_done(600, "zeros_done");
    @(negedge clk);
    check_eq("zeros_result", pops[pops.size() - 1], 32'd0);

    // Spurious strobe in IDLE.
    s_pop = pops.size();
    @(negedge clk); force_ov = 1'b1;
    @(negedge clk); force_ov = 1'b0;
    @(negedge clk);
    check_eq("spur_err",   32'(err), 32'd1);
    check_eq("spur_res",   32'(res_valid), 32'd0);
    check_eq("spur_pops",  32'(pops.size() - s_pop), 32'd0);
    send_cmd(12'h000, 12'h000, 8'd0);
    @(negedge clk);
    check_eq("spur_err_cleared", 32'(err), 32'd0);

    // Reset abort mid-ISSUE.
    mem_mode = 0;
    send_cmd(12'h000, 12'h000, 8'd2);
    repeat (100) @(negedge clk);
    check_eq("abort_in_issue", 32'(a_rd_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("abort_ctl", 32'({cmd_ready, a_rd_en, b_rd_en, in_valid, busy, done, err, res_valid}), 32'd0);
    check_eq("abort_addr", 32'({a_rd_addr, b_rd_addr}), 32'd0);
    check_eq("abort_in_a", in_a, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    check_eq("abort_idle", 32'({busy, cmd_ready}), 32'd1);
    force_ov = 1'b1;
    @(negedge clk); force_ov = 1'b0;
    @(negedge clk);
    check_eq("abort_late_err", 32'(err), 32'd1);
    send_cmd(12'h000, 12'h000, 8'd0);
    @(negedge clk);
    check_eq("abort_err_cleared", 32'(err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
